// File: rtl/counter_ctrl_pkg.sv
// Shared encodings and default widths for the command-driven event counter.
package counter_ctrl_pkg;

  localparam int unsigned DEF_WIDTH      = 4;
  localparam int unsigned DEF_PRESCALE_W = 8;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/counter_ctrl_prescale_tick.sv
// Programmable divider: asserts tick once every div+1 enabled cycles.
module prescale_tick
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned W = DEF_PRESCALE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/counter_ctrl.sv
// Up/down event counter sequenced by START/STOP/LOAD/CLEAR commands.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic                  cfg_dir,
  input  logic                  cfg_reload,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  tc_pulse
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  logic             tc_q, tc_d;
  logic             accept, tick, pre_clr, terminal;
  logic [WIDTH-1:0] reload_val, load_val;

  assign accept     = cmd_valid && ready_q;
  assign pre_clr    = accept && (cmd_op != OP_STOP);
  assign terminal   = cfg_dir ? (count_q == '0) : (count_q >= cfg_limit);
  assign reload_val = cfg_dir ? cfg_limit : '0;
  assign load_val   = (cmd_data > cfg_limit) ? cfg_limit : cmd_data;

  prescale_tick #(.W(PRESCALE_W)) u_prescale (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == S_RUN),
    .clr  (pre_clr),
    .div  (cfg_prescale),
    .tick (tick)
  );

  // An accepted command takes priority; a coincident tick is dropped entirely.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    ready_d = !accept;
    if (accept) begin
      case (cmd_op)
        OP_START: begin
          if (state_q == S_DONE) count_d = reload_val;
          state_d = S_RUN;
        end
        OP_STOP: begin
          if (state_q == S_RUN) state_d = S_IDLE;
        end
        OP_LOAD: begin
          count_d = load_val;
          if (state_q == S_DONE) state_d = S_IDLE;
        end
        default: begin
          count_d = '0;
          state_d = S_IDLE;
        end
      endcase
    end else if (tick) begin
      if (terminal) begin
        tc_d = 1'b1;
        if (cfg_reload) count_d = reload_val;
        else            state_d = S_DONE;
      end else begin
        count_d = cfg_dir ? count_q - 1'b1 : count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ready_q <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= ready_d;
      tc_q    <= tc_d;
    end
  end

  assign cmd_ready = ready_q;
  assign count     = count_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign tc_pulse  = tc_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed scenario bench for counter_ctrl with hand-computed expectations.
module tb_counter_ctrl;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_LOAD  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'd0;
  logic [3:0] cfg_limit = 4'd0;
  logic       cfg_dir = 1'b0;
  logic       cfg_reload = 1'b0;
  logic [7:0] cfg_prescale = 8'd0;
  logic [3:0] count;
  logic       busy, done, tc_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  counter_ctrl #(.WIDTH(4), .PRESCALE_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cfg_limit    (cfg_limit),
    .cfg_dir      (cfg_dir),
    .cfg_reload   (cfg_reload),
    .cfg_prescale (cfg_prescale),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .tc_pulse     (tc_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Waits (bounded) for cmd_ready at a falling edge, presents one command,
  // and returns at the falling edge just after the accepting rising edge.
  task automatic send_cmd(input logic [1:0] op, input logic [3:0] data);
    int unsigned n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL send_ready_timeout: cmd_ready=%b required 1 (op %0d)", cmd_ready, op);
    end else begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({count, busy, done, tc_pulse, cmd_ready} !== 8'h00)
      $display("FAIL reset_outputs: count=%0d busy=%b done=%b tc=%b ready=%b required all 0",
               count, busy, done, tc_pulse, cmd_ready);
    else n_pass++;
    rst = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b0) $display("FAIL reset_ready_release: ready=%b required 0", cmd_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready_rise: ready=%b required 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_oneshot_up();
    cfg_dir = 1'b0; cfg_limit = 4'd5; cfg_reload = 1'b0; cfg_prescale = 8'd0;
    send_cmd(C_START, 4'd0);
    n_checks++;
    if (busy !== 1'b1 || count !== 4'd0)
      $display("FAIL up_start: busy=%b count=%0d required busy=1 count=0", busy, count);
    else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (count !== 4'(i) || tc_pulse !== 1'b0)
        $display("FAIL up_step%0d: count=%0d tc=%b required count=%0d tc=0", i, count, tc_pulse, i);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (tc_pulse !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || count !== 4'd5)
      $display("FAIL up_terminal: tc=%b done=%b busy=%b count=%0d required 1 1 0 5",
               tc_pulse, done, busy, count);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tc_pulse !== 1'b0 || count !== 4'd5 || done !== 1'b1)
      $display("FAIL up_hold: tc=%b count=%0d done=%b required 0 5 1", tc_pulse, count, done);
    else n_pass++;
  endtask

  task automatic test_wrap_reload();
    cfg_prescale = 8'd3; cfg_limit = 4'd15; cfg_reload = 1'b1;
    send_cmd(C_LOAD, 4'd13);
    n_checks++;
    if (count !== 4'd13 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL wrap_load: count=%0d done=%b busy=%b required 13 0 0", count, done, busy);
    else n_pass++;
    send_cmd(C_START, 4'd0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (count !== 4'd13) $display("FAIL wrap_pre_tick: count=%0d required 13", count);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (count !== 4'd14) $display("FAIL wrap_tick1: count=%0d required 14", count);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (count !== 4'd15 || tc_pulse !== 1'b0)
      $display("FAIL wrap_tick2: count=%0d tc=%b required 15 0", count, tc_pulse);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (count !== 4'd0 || tc_pulse !== 1'b1 || busy !== 1'b1)
      $display("FAIL wrap_terminal: count=%0d tc=%b busy=%b required 0 1 1", count, tc_pulse, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tc_pulse !== 1'b0 || busy !== 1'b1)
      $display("FAIL wrap_after: tc=%b busy=%b required 0 1", tc_pulse, busy);
    else n_pass++;
  endtask

  task automatic test_load_stop();
    send_cmd(C_CLEAR, 4'd0);
    cfg_limit = 4'd7;
    send_cmd(C_LOAD, 4'd12);
    n_checks++;
    if (count !== 4'd7) $display("FAIL load_clamp: count=%0d required 7", count);
    else n_pass++;
    cfg_limit = 4'd15; cfg_prescale = 8'd0; cfg_reload = 1'b0; cfg_dir = 1'b0;
    send_cmd(C_START, 4'd0);
    @(negedge clk);
    n_checks++;
    if (count !== 4'd8) $display("FAIL stop_run: count=%0d required 8", count);
    else n_pass++;
    send_cmd(C_STOP, 4'd0);
    n_checks++;
    if (count !== 4'd8 || busy !== 1'b0 || tc_pulse !== 1'b0)
      $display("FAIL stop_freeze: count=%0d busy=%b tc=%b required 8 0 0", count, busy, tc_pulse);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (count !== 4'd8 || busy !== 1'b0)
      $display("FAIL stop_hold: count=%0d busy=%b required 8 0", count, busy);
    else n_pass++;
  endtask

  task automatic test_down_oneshot();
    cfg_dir = 1'b1; cfg_limit = 4'd9; cfg_reload = 1'b0; cfg_prescale = 8'd0;
    send_cmd(C_LOAD, 4'd3);
    send_cmd(C_START, 4'd0);
    n_checks++;
    if (count !== 4'd3 || busy !== 1'b1)
      $display("FAIL down_start: count=%0d busy=%b required 3 1", count, busy);
    else n_pass++;
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk);
      n_checks++;
      if (count !== 4'(i) || tc_pulse !== 1'b0)
        $display("FAIL down_step%0d: count=%0d tc=%b required count=%0d tc=0", i, count, tc_pulse, i);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (tc_pulse !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || count !== 4'd0)
      $display("FAIL down_terminal: tc=%b done=%b busy=%b count=%0d required 1 1 0 0",
               tc_pulse, done, busy, count);
    else n_pass++;
    send_cmd(C_START, 4'd0);
    n_checks++;
    if (count !== 4'd9 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL down_restart: count=%0d busy=%b done=%b required 9 1 0", count, busy, done);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (count !== 4'd8) $display("FAIL down_restart_step: count=%0d required 8", count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send_cmd(C_CLEAR, 4'd0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = C_LOAD; cmd_data = 4'd4;
    @(negedge clk);
    n_checks++;
    if (count !== 4'd4 || cmd_ready !== 1'b0)
      $display("FAIL b2b_first: count=%0d ready=%b required 4 0", count, cmd_ready);
    else n_pass++;
    cmd_data = 4'd6;
    @(negedge clk);
    n_checks++;
    if (count !== 4'd4 || cmd_ready !== 1'b1)
      $display("FAIL b2b_gap: count=%0d ready=%b required 4 1", count, cmd_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (count !== 4'd6 || cmd_ready !== 1'b0)
      $display("FAIL b2b_second: count=%0d ready=%b required 6 0", count, cmd_ready);
    else n_pass++;
    cmd_valid = 1'b0;
  endtask

  task automatic test_limit_zero();
    cfg_dir = 1'b0; cfg_limit = 4'd0; cfg_reload = 1'b1; cfg_prescale = 8'd0;
    send_cmd(C_START, 4'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (count !== 4'd0 || tc_pulse !== 1'b1 || busy !== 1'b1)
        $display("FAIL limit0_tick%0d: count=%0d tc=%b busy=%b required 0 1 1", i, count, tc_pulse, busy);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    send_cmd(C_CLEAR, 4'd0);
    cfg_dir = 1'b0; cfg_limit = 4'd3; cfg_reload = 1'b0; cfg_prescale = 8'd1;
    send_cmd(C_LOAD, 4'd3);
    send_cmd(C_START, 4'd0);
    send_cmd(C_CLEAR, 4'd0);
    n_checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || tc_pulse !== 1'b0)
      $display("FAIL collide_clear: count=%0d busy=%b done=%b tc=%b required 0 0 0 0",
               count, busy, done, tc_pulse);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tc_pulse !== 1'b0 || done !== 1'b0)
      $display("FAIL collide_after: tc=%b done=%b required 0 0", tc_pulse, done);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    cfg_dir = 1'b0; cfg_limit = 4'd15; cfg_reload = 1'b0; cfg_prescale = 8'd3;
    send_cmd(C_LOAD, 4'd6);
    send_cmd(C_START, 4'd0);
    n_checks++;
    if (count !== 4'd6 || busy !== 1'b1)
      $display("FAIL areset_pre: count=%0d busy=%b required 6 1", count, busy);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({count, busy, done, tc_pulse, cmd_ready} !== 8'h00)
      $display("FAIL areset_immediate: count=%0d busy=%b done=%b tc=%b ready=%b required all 0",
               count, busy, done, tc_pulse, cmd_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b0) $display("FAIL areset_ready_low: ready=%b required 0", cmd_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || count !== 4'd0 || busy !== 1'b0)
      $display("FAIL areset_release: ready=%b count=%0d busy=%b required 1 0 0", cmd_ready, count, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_oneshot_up();
    test_wrap_reload();
    test_load_stop();
    test_down_oneshot();
    test_back_to_back();
    test_limit_zero();
    test_collision();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
